// File: rtl/handshake_pipe_full_patting_pkg.sv
// Shared definitions for the fully registered valid/ready pipe stage.
// Contents:
//   DATA_W_DEFAULT : default payload width
//   state_e        : storage state (EMPTY/BUSY/FULL = 0/1/2 stored beats)
//   occ_of()       : beat count for a given state
package handshake_pipe_full_patting_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/handshake_pipe_full_patting.sv
// Two-entry valid/ready pipe stage with every output registered.
// A main register feeds slave_data; a skid register catches the one beat
// that can arrive while the downstream stalls, so master_ready can itself
// be a flop without losing data.
//
// state | meaning
// EMPTY | no beat stored, slave_valid=0, master_ready=1
// BUSY  | one beat in main, slave_valid=1, master_ready=1
// FULL  | beats in main and skid, slave_valid=1, master_ready=0
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   master_valid   : upstream beat valid
//   master_data    : upstream payload
//   master_ready   : stage can take a beat (flop)
//   slave_valid    : downstream beat valid (flop)
//   slave_data     : downstream payload (flop)
//   slave_ready    : downstream takes the beat
//   occupancy      : stored beats, 0..2 (flop)
module handshake_pipe_full_patting
  import handshake_pipe_full_patting_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              master_valid,
  input  logic [DATA_W-1:0] master_data,
  output logic              master_ready,
  output logic              slave_valid,
  output logic [DATA_W-1:0] slave_data,
  input  logic              slave_ready,
  output logic [1:0]        occupancy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              valid_q, ready_q;
  logic [1:0]        occ_q;
  logic              m_fire, s_fire;

  // Handshakes use the registered flags, never the inputs alone, so no
  // input reaches an output combinationally.
  assign m_fire = master_valid & ready_q;
  assign s_fire = valid_q & slave_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (m_fire) begin
          state_d = BUSY;
          main_d  = master_data;
        end
      end
      BUSY: begin
        if (m_fire && !s_fire) begin
          state_d = FULL;
          skid_d  = master_data;
        end else if (m_fire && s_fire) begin
          main_d  = master_data;
        end else if (s_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // master_ready is low here, so only the drain side can move.
        if (s_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      // Flags are decoded from the next state so they line up with state_q.
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      occ_q   <= occ_of(state_d);
    end
  end

  assign master_ready = ready_q;
  assign slave_valid  = valid_q;
  assign slave_data   = main_q;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_handshake_pipe_full_patting.sv
module tb_handshake_pipe_full_patting;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        master_valid;
  logic [31:0] master_data;
  logic        master_ready;
  logic        slave_valid;
  logic [31:0] slave_data;
  logic        slave_ready;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  handshake_pipe_full_patting #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .master_valid (master_valid),
    .master_data  (master_data),
    .master_ready (master_ready),
    .slave_valid  (slave_valid),
    .slave_data   (slave_data),
    .slave_ready  (slave_ready),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic r,
                         input logic [1:0] occ, input logic [31:0] d);
    chk({tag, ".valid"}, {31'd0, slave_valid}, {31'd0, v});
    chk({tag, ".ready"}, {31'd0, master_ready}, {31'd0, r});
    chk({tag, ".occ"}, {30'd0, occupancy}, {30'd0, occ});
    if (v) chk({tag, ".data"}, slave_data, d);
  endtask

  initial begin
    rst_n        = 1'b0;
    master_valid = 1'b0;
    master_data  = '0;
    slave_ready  = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b1, 2'd0, 32'h0);
    chk("reset.data0", slave_data, 32'h0);
    rst_n = 1'b1;
    tick();
    chk_out("idle", 1'b0, 1'b1, 2'd0, 32'h0);

    // Streaming with slave_ready held high: one beat per cycle, never FULL.
    slave_ready  = 1'b1;
    master_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      master_data = i;
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, i);
    end
    master_valid = 1'b0;
    tick();
    chk_out("stream_end", 1'b0, 1'b1, 2'd0, 32'h0);

    // Backpressure: two beats fill the stage, a third is ignored.
    slave_ready  = 1'b0;
    master_valid = 1'b1;
    master_data  = 32'hA;
    tick();
    chk_out("bp_a", 1'b1, 1'b1, 2'd1, 32'hA);
    master_data = 32'hB;
    tick();
    chk_out("bp_full", 1'b1, 1'b0, 2'd2, 32'hA);
    master_data = 32'hC;
    tick();
    chk_out("bp_ignore_c", 1'b1, 1'b0, 2'd2, 32'hA);
    master_valid = 1'b0;
    tick();
    chk_out("bp_hold", 1'b1, 1'b0, 2'd2, 32'hA);

    // Drain: A leaves on the first edge, then B.
    slave_ready = 1'b1;
    tick();
    chk_out("drain1", 1'b1, 1'b1, 2'd1, 32'hB);
    tick();
    chk_out("drain2", 1'b0, 1'b1, 2'd0, 32'h0);
    tick();
    chk_out("drain_no_c", 1'b0, 1'b1, 2'd0, 32'h0);

    // slave_ready toggling while empty does nothing.
    slave_ready = 1'b0;
    tick();
    slave_ready = 1'b1;
    tick();
    chk_out("toggle_empty", 1'b0, 1'b1, 2'd0, 32'h0);

    // Simultaneous accept and deliver while BUSY.
    slave_ready  = 1'b0;
    master_valid = 1'b1;
    master_data  = 32'h5;
    tick();
    chk_out("sim_hold5", 1'b1, 1'b1, 2'd1, 32'h5);
    master_data = 32'h6;
    slave_ready = 1'b1;
    tick();
    chk_out("sim_swap6", 1'b1, 1'b1, 2'd1, 32'h6);
    master_valid = 1'b0;
    tick();
    chk_out("sim_empty", 1'b0, 1'b1, 2'd0, 32'h0);

    // Mid-operation reset from FULL.
    slave_ready  = 1'b0;
    master_valid = 1'b1;
    master_data  = 32'h11;
    tick();
    master_data = 32'h12;
    tick();
    master_valid = 1'b0;
    chk_out("pre_rst_full", 1'b1, 1'b0, 2'd2, 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b1, 2'd0, 32'h0);
    chk("async_rst.data0", slave_data, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("post_rst_idle", 1'b0, 1'b1, 2'd0, 32'h0);
    master_valid = 1'b1;
    master_data  = 32'h7;
    tick();
    master_valid = 1'b0;
    chk_out("post_rst_7", 1'b1, 1'b1, 2'd1, 32'h7);
    slave_ready = 1'b1;
    tick();
    chk_out("post_rst_alone", 1'b0, 1'b1, 2'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
